ahb_sram_slave: RTL

AHB-lite responder that sits on the far side of the CPU bus mux output. It terminates the 64-bit AHB bus from the bus unit arbiter and serves it from a synchronous single-port SRAM with 1-cycle read latency. It supports pipelined address and data phases, byte, half, word and dword sizes, configurable wait states, and a two-cycle ERROR response for illegal accesses.

---
 rtl/ahb_sram_slave_if.sv | 26 ++
 rtl/ahb_sram_slave.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/ahb_sram_slave_if.sv
// AHB-lite bus bundle between the bus-unit arbiter (master side) and the SRAM responder.
interface ahb_sram_slave_if;
   logic        hsel;
   logic [63:0] haddr;
   logic        hwrite;
   logic [3:0]  hsize;
   logic [2:0]  hburst;
   logic [3:0]  hprot;
   logic [1:0]  htrans;
   logic        hmastlock;
   logic [63:0] hwdata;
   logic        hready;
   logic        hreadyout;
   logic        hresp;
   logic [63:0] hrdata;

   modport master (
      output hsel, haddr, hwrite, hsize, hburst, hprot, htrans, hmastlock, hwdata, hready,
      input  hreadyout, hresp, hrdata
   );

   modport slave (
      input  hsel, haddr, hwrite, hsize, hburst, hprot, htrans, hmastlock, hwdata, hready,
      output hreadyout, hresp, hrdata
   );
endinterface

// File: rtl/ahb_sram_slave.sv
// AHB-lite responder serving a 64-bit synchronous single-port SRAM (1-cycle read latency),
// with pipelined address/data phases, configurable wait states and two-cycle ERROR.
module ahb_sram_slave #(
   parameter int          AW       = 12,
   parameter logic [63:0] BASE     = 64'h0,
   parameter int          WAIT_CYC = 0
) (
   input  logic          clk,
   input  logic          rst,
   ahb_sram_slave_if.slave bus,
   output logic          sram_ce,
   output logic          sram_we,
   output logic [AW-1:0] sram_addr,
   output logic [7:0]    sram_be,
   output logic [63:0]   sram_wdata,
   input  logic [63:0]   sram_rdata
);
   typedef enum logic [2:0] {IDLE, WR, RD, RDW, ERR1, ERR2} state_t;

   localparam logic [3:0] WAIT_LD = 4'(WAIT_CYC);

   state_t        state;
   logic [3:0]    cnt;
   logic [AW-1:0] addr_q;
   logic [7:0]    be_q;
   logic          hreadyout_q, hresp_q, ce_q, we_q, rd_done;
   logic [63:0]   hrdata_q;

   logic [64:0]   off;
   logic [7:0]    be_d;
   logic          acc, err, misalign;

   // Bit 64 of the widened difference is the borrow, i.e. haddr below the window.
   assign off = {1'b0, bus.haddr} - {1'b0, BASE};
   assign acc = bus.hsel & bus.hready & bus.htrans[1];

   always_comb begin
      misalign = 1'b0;
      be_d     = 8'h00;
      case (bus.hsize)
         4'd0: be_d = 8'h01 << bus.haddr[2:0];
         4'd1: begin
            misalign = bus.haddr[0];
            be_d     = 8'h03 << {bus.haddr[2:1], 1'b0};
         end
         4'd2: begin
            misalign = |bus.haddr[1:0];
            be_d     = 8'h0F << {bus.haddr[2], 2'b00};
         end
         4'd3: begin
            misalign = |bus.haddr[2:0];
            be_d     = 8'hFF;
         end
         default: ;
      endcase
   end

   assign err = (bus.hsize > 4'd3) | misalign | off[64] | (|off[63:AW+3]);

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         addr_q      <= '0;
         be_q        <= '0;
         hreadyout_q <= 1'b1;
         hresp_q     <= 1'b0;
         ce_q        <= 1'b0;
         we_q        <= 1'b0;
         rd_done     <= 1'b0;
         hrdata_q    <= '0;
      end else if (hreadyout_q) begin
         // Data phase (or idle) ends this cycle; a concurrent accept chains straight on.
         if (rd_done) hrdata_q <= sram_rdata;
         state       <= IDLE;
         cnt         <= '0;
         hreadyout_q <= 1'b1;
         hresp_q     <= 1'b0;
         ce_q        <= 1'b0;
         we_q        <= 1'b0;
         rd_done     <= 1'b0;
         if (acc) begin
            addr_q <= off[AW+2:3];
            be_q   <= be_d;
            if (err) begin
               state       <= ERR1;
               hreadyout_q <= 1'b0;
               hresp_q     <= 1'b1;
            end else if (bus.hwrite) begin
               state       <= WR;
               cnt         <= WAIT_LD;
               hreadyout_q <= (WAIT_LD == 4'd0);
               ce_q        <= (WAIT_LD == 4'd0);
               we_q        <= (WAIT_LD == 4'd0);
            end else begin
               state       <= RD;
               cnt         <= WAIT_LD;
               hreadyout_q <= 1'b0;
               ce_q        <= 1'b1;
            end
         end
      end else begin
         case (state)
            WR: begin
               cnt <= cnt - 4'd1;
               if (cnt == 4'd1) begin
                  hreadyout_q <= 1'b1;
                  ce_q        <= 1'b1;
                  we_q        <= 1'b1;
               end
            end
            RD: begin
               state <= RDW;
               ce_q  <= 1'b0;
               if (cnt == 4'd0) begin
                  hreadyout_q <= 1'b1;
                  rd_done     <= 1'b1;
               end
            end
            RDW: begin
               cnt <= cnt - 4'd1;
               if (cnt == 4'd1) begin
                  hreadyout_q <= 1'b1;
                  rd_done     <= 1'b1;
               end
            end
            ERR1: begin
               state       <= ERR2;
               hreadyout_q <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.hreadyout = hreadyout_q;
   assign bus.hresp     = hresp_q;
   // SRAM data arrives in the completing cycle; present it directly, then hold the captured copy.
   assign bus.hrdata    = rd_done ? sram_rdata : hrdata_q;

   assign sram_ce    = ce_q & ~rst;
   assign sram_we    = we_q & ~rst;
   assign sram_be    = (we_q & ~rst) ? be_q : 8'h00;
   assign sram_addr  = addr_q;
   assign sram_wdata = bus.hwdata;

   logic unused_ok;
   assign unused_ok = ^{bus.hburst, bus.hprot, bus.hmastlock, bus.htrans[0], off[2:0]};
endmodule
